// File: rtl/reg_dump_engine.sv
// rtl/reg_dump_engine.sv - register-file dump sweep engine with ready/valid output and running checksum
module reg_dump_engine (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] reg_mask,
    output logic [3:0]  gp_register_select,
    input  logic [31:0] BusMuxOut,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic [3:0]  dump_index,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        OUTPUT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pending;
    logic [15:0] remaining;
    logic        handshake;
    logic [3:0]  sel;

    // Lowest set bit of a mask; callers only use the result when the mask is non-zero.
    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // sel doubles as the sweep index: it is only updated when the next register is chosen,
    // so it naturally holds its last value through IDLE and DONE.
    assign gp_register_select = sel;
    assign busy               = (state != IDLE);
    assign done               = (state == DONE);

    // Abort wins over a coincident handshake, so the word on the bus is not counted.
    assign handshake = (state == OUTPUT) && dump_ready && !abort;
    assign remaining = pending & ~(16'd1 << sel);

    // State register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (reg_mask == 16'd0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                state_next = abort ? IDLE : OUTPUT;
            end
            OUTPUT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (dump_ready) begin
                    state_next = (remaining == 16'd0) ? DONE : SELECT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath: pending mask, select index, captured word and running checksum.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pending    <= 16'd0;
            sel        <= 4'd0;
            dump_valid <= 1'b0;
            dump_data  <= 32'd0;
            dump_index <= 4'd0;
            checksum   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending  <= reg_mask;
                        checksum <= 32'd0;
                        if (reg_mask != 16'd0) begin
                            sel <= lowest_set(reg_mask);
                        end
                    end
                end
                SELECT: begin
                    if (abort) begin
                        pending <= 16'd0;
                    end else begin
                        dump_data  <= BusMuxOut;
                        dump_index <= sel;
                        dump_valid <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (abort) begin
                        pending    <= 16'd0;
                        dump_valid <= 1'b0;
                    end else if (handshake) begin
                        checksum   <= checksum + dump_data;
                        pending    <= remaining;
                        dump_valid <= 1'b0;
                        if (remaining != 16'd0) begin
                            sel <= lowest_set(remaining);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/reg_dump_engine.md
REG_DUMP_ENGINE -- requirements
Module: reg_dump_engine

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request a dump sweep; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1, synchronous sweep cancel.
REQ-005 SHALL have port reg_mask, input, 16, bit i set means dump register Ri; sampled with start.
REQ-006 SHALL have port gp_register_select, output, 4, register-file read select driven to the bus mux.
REQ-007 SHALL have port BusMuxOut, input, 32, bus value of the currently selected register.
REQ-008 SHALL have port dump_valid, output, 1, dump_data/dump_index are valid.
REQ-009 SHALL have port dump_ready, input, 1, downstream accepts the current word.
REQ-010 SHALL have port dump_data, output, 32, captured register value.
REQ-011 SHALL have port dump_index, output, 4, register number of dump_data.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on sweep completion.
REQ-014 SHALL have port checksum, output, 32, modulo-2^32 sum of all words accepted in the current/last sweep.

Function
REQ-015 SHALL implement states IDLE, SELECT, OUTPUT, DONE.
REQ-016 IDLE: start=1 at an edge SHALL latch reg_mask into the pending mask, zero checksum, and go to SELECT with index = lowest set bit; start SHALL be ignored outside IDLE.
REQ-017 start with reg_mask=0 SHALL go directly to DONE; no dump_valid, checksum=0.
REQ-018 SELECT: gp_register_select SHALL equal index for the whole cycle; at the next edge dump_data<=BusMuxOut, dump_index<=index, dump_valid<=1, state<=OUTPUT.
REQ-019 OUTPUT: dump_valid, dump_data, dump_index SHALL hold stable until an edge with dump_ready=1 (handshake).
REQ-020 On handshake: checksum<=checksum+dump_data (carry discarded), clear the index bit in the pending mask, dump_valid<=0; if bits remain, go to SELECT with the next higher set bit, else go to DONE.
REQ-021 Registers SHALL be visited in strictly ascending index order; each set bit exactly once; unset bits skipped with no extra cycles.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE's following cycle.
REQ-023 Latency: start edge to dump_valid high = 2 edges; with dump_ready held 1, throughput = one word per 2 cycles; full mask completes in 32 cycles plus 1 DONE cycle.
REQ-024 abort=1 at an edge in SELECT/OUTPUT SHALL return to IDLE, drop dump_valid, skip done, keep checksum of words already accepted; abort has priority over a coincident handshake (that word is not counted); abort in IDLE/DONE has no effect.
REQ-025 gp_register_select SHALL hold its last value while in IDLE and DONE.
REQ-026 checksum and dump_data/dump_index SHALL hold their values after DONE until the next accepted start.

Reset
REQ-027 clear=0 SHALL immediately, independent of clock, force state IDLE, pending mask 0, gp_register_select 0, dump_valid 0, dump_data 0, dump_index 0, busy 0, done 0, checksum 0.
REQ-028 clear asserted mid-sweep SHALL discard the sweep; after release no output activity until a new start.

Verification
REQ-029 Ri preloaded with i, start, reg_mask=16'hFFFF, dump_ready=1 -> 16 words, indices 0..15 in order, data=index, done at cycle 33, checksum=120 (0x78).
REQ-030 reg_mask=16'h8421, Ri=32'h1000_0000+i -> words for R0,R5,R10,R15 only; checksum=32'h4000_001E.
REQ-031 R3=32'hDEAD_BEEF, mask=16'h0008, dump_ready low 5 cycles -> dump_valid/data/index stable 5 cycles, single handshake, checksum=32'hDEAD_BEEF.
REQ-032 R0=R1=32'hFFFF_FFFF, mask=16'h0003 -> checksum=32'hFFFF_FFFE (wrap); start=1 during sweep ignored.
REQ-033 mask=16'h0000 -> done pulse 1 edge after start, no dump_valid; abort in second OUTPUT of mask=16'h00FF -> IDLE, no done, checksum = first word only.
REQ-034 clear=0 while in OUTPUT of a full-mask sweep -> all outputs at reset values before next edge; new start afterwards begins at R0.
